codec_i2c_init_seq: RTL and testbench
=====================================

// Module: codec_i2c_init_seq
// PURPOSE
//  Power-up configuration sequencer for the WM8731 codec. On a start pulse, walks a fixed
//  11-entry register table and hands each write to the I2C master in controlador as a 24-bit
//  i2c_packet plus a one-cycle wr_i2c strobe, pacing on i2c_idle.
//  Sits directly upstream of controlador's i2c_packet/wr_i2c inputs. Replaces host-driven setup.
// PARAMETERS
//  DEV_ADDR     8'h34     I2C write address byte (CSB=0), packet bits [23:16]
//  DAI_FMT      9'h042    R7 digital audio interface value (master, I2S, 16-bit)
//  SAMPLE_CTRL  9'h000    R8 sampling control value (normal mode, 48 kHz)
//  TIMEOUT_CYC  50000     max cycles in each wait state before error; must be >= 2
//  GAP_CYC      16        idle cycles inserted after each completed write; must be >= 1
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  start        in   1   begin sequence; sampled only in IDLE, DONE or ERROR
//  i2c_idle     in   1   I2C master idle: 1 = ready, 0 = transfer in progress
//  i2c_packet   out  24  {DEV_ADDR, reg[6:0], data[8], data[7:0]}
//  wr_i2c       out  1   one-cycle write strobe to the I2C master
//  busy         out  1   sequence in progress
//  done         out  1   all 11 writes completed; held until next start
//  err          out  1   handshake timeout; held until next start
//  err_index    out  4   table index of the write that timed out
// BEHAVIOUR
//  Clock and reset: one clock (clk); synchronous, active-high reset.
//  Reset: state=IDLE, idx=0, all counters 0, i2c_packet=0, wr_i2c=0, busy=0, done=0,
//   err=0, err_index=0. All outputs registered. Reset mid-sequence aborts at the next
//   edge; no further wr_i2c is issued.
//  Table (idx: reg, data): 0:R15 0x000 (reset); 1:R0 0x017; 2:R1 0x017; 3:R2 0x079;
//   4:R3 0x079; 5:R4 0x012; 6:R5 0x000; 7:R6 0x000; 8:R7 DAI_FMT; 9:R8 SAMPLE_CTRL;
//   10:R9 0x001 (active, always last).
//  FSM:
//   IDLE        busy=0. start=1 -> idx=0, clear done/err, go to ISSUE.
//   ISSUE       If i2c_idle=1: load i2c_packet=table[idx], pulse wr_i2c=1, go to WAIT_ACCEPT.
//               If i2c_idle=0: stay and count toward timeout.
//   WAIT_ACCEPT Wait for i2c_idle=0, then go to WAIT_DONE.
//   WAIT_DONE   Wait for i2c_idle=1, then go to GAP.
//   GAP         Count GAP_CYC cycles. Then idx==10 -> DONE; else idx+1 -> ISSUE.
//   DONE        done=1, busy=0. start -> restart at idx 0.
//   ERROR       err=1, busy=0, err_index=idx. start -> restart at idx 0.
//  busy=1 in ISSUE, WAIT_ACCEPT, WAIT_DONE and GAP. start is ignored while busy.
//  Timeout:
//   - Counter clears on entry to ISSUE, WAIT_ACCEPT and WAIT_DONE.
//   - Increments every cycle the exit condition is false.
//   - Counter == TIMEOUT_CYC-1 with the condition still false -> ERROR at the next edge.
//   - Exit condition and timeout true on the same edge: the exit condition wins.
//  Latency: start sampled at edge N -> ISSUE at N. With i2c_idle=1, wr_i2c is high from
//   edge N+1 to N+2 (exactly one cycle). i2c_packet is valid in that same cycle and stays
//   stable until the next ISSUE load.
//  wr_i2c never asserts twice without an intervening i2c_idle 1->0->1 sequence.
// TESTING
//  1. Model the master: i2c_idle drops 2 cycles after wr_i2c and returns 100 cycles later.
//     Pulse start -> 11 wr_i2c pulses; packets 0x341E00, 0x340017, ..., 0x341201 in table
//     order; done=1 and busy=0 after the last GAP.
//  2. Hold i2c_idle=1 forever -> WAIT_ACCEPT times out -> err=1, err_index=0,
//     wr_i2c pulsed exactly once.
//  3. Stall the master low during write 5 -> ERROR after exactly TIMEOUT_CYC cycles in
//     WAIT_DONE, err_index=5.
//  4. Pulse start again mid-sequence -> ignored, sequence unchanged. Then assert reset at
//     write 3 -> next edge IDLE, all outputs 0, no further strobes.
//  5. From DONE, and separately from ERROR, pulse start -> done/err clear and a full
//     11-write sequence reruns.
//  6. Override DAI_FMT=9'h04A and SAMPLE_CTRL=9'h00C -> packets 8 and 9 equal
//     0x340E4A and 0x34100C.

Source files
------------

// File: rtl/codec_i2c_init_seq.sv
// WM8731 power-up sequencer: on start, writes an 11-entry register table to the I2C master.
// wr_i2c rises one cycle after ISSUE; each write is paced on the i2c_idle 1->0->1 handshake and times out to ERROR.
module codec_i2c_init_seq #(
    parameter logic [7:0] DEV_ADDR    = 8'h34,
    parameter logic [8:0] DAI_FMT     = 9'h042,
    parameter logic [8:0] SAMPLE_CTRL = 9'h000,
    parameter int         TIMEOUT_CYC = 50000,
    parameter int         GAP_CYC     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        i2c_idle,
    output logic [23:0] i2c_packet,
    output logic        wr_i2c,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  err_index
);

    localparam int MAXC = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
    localparam logic [3:0]    IDX_LAST = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_ACCEPT, S_WAIT_DONE, S_GAP, S_DONE, S_ERROR
    } state_t;

    state_t          state_q;
    logic [3:0]      idx_q;
    logic [CW-1:0]   cnt_q;
    logic [23:0]     pkt_q;
    logic            wr_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic [3:0]      err_index_q;
    logic [23:0]     pkt_d;
    logic [6:0]      reg_addr;
    logic [8:0]      reg_data;

    // R9 (activate) must stay last so the codec only starts once fully configured
    always_comb begin
        reg_addr = 7'd0;
        reg_data = 9'h000;
        case (idx_q)
            4'd0:    begin reg_addr = 7'd15; reg_data = 9'h000;      end
            4'd1:    begin reg_addr = 7'd0;  reg_data = 9'h017;      end
            4'd2:    begin reg_addr = 7'd1;  reg_data = 9'h017;      end
            4'd3:    begin reg_addr = 7'd2;  reg_data = 9'h079;      end
            4'd4:    begin reg_addr = 7'd3;  reg_data = 9'h079;      end
            4'd5:    begin reg_addr = 7'd4;  reg_data = 9'h012;      end
            4'd6:    begin reg_addr = 7'd5;  reg_data = 9'h000;      end
            4'd7:    begin reg_addr = 7'd6;  reg_data = 9'h000;      end
            4'd8:    begin reg_addr = 7'd7;  reg_data = DAI_FMT;     end
            4'd9:    begin reg_addr = 7'd8;  reg_data = SAMPLE_CTRL; end
            4'd10:   begin reg_addr = 7'd9;  reg_data = 9'h001;      end
            default: begin reg_addr = 7'd0;  reg_data = 9'h000;      end
        endcase
        pkt_d = {DEV_ADDR, reg_addr, reg_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= 4'd0;
            cnt_q       <= '0;
            pkt_q       <= 24'd0;
            wr_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_index_q <= 4'd0;
        end else begin
            wr_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        idx_q   <= 4'd0;
                        cnt_q   <= '0;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE, S_WAIT_ACCEPT, S_WAIT_DONE: begin
                    // exit condition has priority over the timeout on the same edge
                    if ((state_q == S_ISSUE       &&  i2c_idle) ||
                        (state_q == S_WAIT_ACCEPT && !i2c_idle) ||
                        (state_q == S_WAIT_DONE   &&  i2c_idle)) begin
                        cnt_q <= '0;
                        case (state_q)
                            S_ISSUE: begin
                                pkt_q   <= pkt_d;
                                wr_q    <= 1'b1;
                                state_q <= S_WAIT_ACCEPT;
                            end
                            S_WAIT_ACCEPT: state_q <= S_WAIT_DONE;
                            default:       state_q <= S_GAP;
                        endcase
                    end else if (cnt_q == TO_LAST) begin
                        err_q       <= 1'b1;
                        busy_q      <= 1'b0;
                        err_index_q <= idx_q;
                        state_q     <= S_ERROR;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q <= '0;
                        if (idx_q == IDX_LAST) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= S_ISSUE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign i2c_packet = pkt_q;
    assign wr_i2c     = wr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_index  = err_index_q;

endmodule

// File: tb/tb_codec_i2c_init_seq.sv
// Directed bench for codec_i2c_init_seq: behavioural I2C master, packet capture, hand-computed table.
module tb_codec_i2c_init_seq;

    localparam int TIMEOUT = 300;
    localparam int GAP     = 16;

    logic        clk;
    logic        reset;
    logic        start;
    logic        i2c_idle;
    logic [23:0] i2c_packet, i2c_packet2;
    logic        wr_i2c, wr_i2c2;
    logic        busy, busy2;
    logic        done, done2;
    logic        err, err2;
    logic [3:0]  err_index, err_index2;

    codec_i2c_init_seq #(.TIMEOUT_CYC(TIMEOUT), .GAP_CYC(GAP)) dut (
        .clk(clk), .reset(reset), .start(start), .i2c_idle(i2c_idle),
        .i2c_packet(i2c_packet), .wr_i2c(wr_i2c), .busy(busy), .done(done),
        .err(err), .err_index(err_index)
    );

    codec_i2c_init_seq #(.DAI_FMT(9'h04A), .SAMPLE_CTRL(9'h00C),
                         .TIMEOUT_CYC(TIMEOUT), .GAP_CYC(GAP)) dut2 (
        .clk(clk), .reset(reset), .start(start), .i2c_idle(i2c_idle),
        .i2c_packet(i2c_packet2), .wr_i2c(wr_i2c2), .busy(busy2), .done(done2),
        .err(err2), .err_index(err_index2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [23:0] exp_pkt [0:10] = '{24'h341E00, 24'h340017, 24'h340217, 24'h340479,
                                    24'h340679, 24'h340812, 24'h340A00, 24'h340C00,
                                    24'h340E42, 24'h341000, 24'h341201};

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // packet capture for both instances
    logic [23:0] pk  [0:255];
    logic [23:0] pk2 [0:255];
    int npk = 0, npk2 = 0;
    int base = 0, base2 = 0;

    always @(negedge clk) begin
        if (wr_i2c) begin
            if (npk < 256) pk[npk] = i2c_packet;
            npk++;
        end
        if (wr_i2c2) begin
            if (npk2 < 256) pk2[npk2] = i2c_packet2;
            npk2++;
        end
    end

    // I2C master: goes busy 2 cycles after a strobe, idle again 100 cycles later
    logic hold_high = 1'b0;
    logic stall_en  = 1'b0;
    int   stall_idx = 0;
    int   mcount    = 0;
    time  drop_t    = 0;

    initial begin
        i2c_idle = 1'b1;
        forever begin
            @(negedge clk);
            if (wr_i2c && !hold_high) begin
                repeat (2) @(negedge clk);
                i2c_idle = 1'b0;
                drop_t   = $time;
                repeat (100) @(negedge clk);
                while (stall_en && mcount == stall_idx) @(negedge clk);
                i2c_idle = 1'b1;
                mcount++;
            end
        end
    end

    task automatic start_seq(input string tag);
        @(negedge clk);
        start  = 1'b1;
        base   = npk;
        base2  = npk2;
        mcount = 0;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_done_clr"}, done, 0);
        chk({tag, "_err_clr"}, err, 0);
        chk({tag, "_wr_lat0"}, wr_i2c, 0);
        @(negedge clk);
        chk({tag, "_wr_lat1"}, wr_i2c, 1);
        chk({tag, "_pkt0"}, i2c_packet, exp_pkt[0]);
        @(negedge clk);
        chk({tag, "_wr_1cyc"}, wr_i2c, 0);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_err_end"}, err, 0);
    endtask

    task automatic wait_err(input string tag);
        for (int i = 0; i < 3000 && !err; i++) @(negedge clk);
        chk({tag, "_err"}, err, 1);
        chk({tag, "_busy_err"}, busy, 0);
        chk({tag, "_done_err"}, done, 0);
    endtask

    task automatic check_seq(input string tag);
        chk({tag, "_nwr"}, npk - base, 11);
        for (int i = 0; i < 11; i++)
            chk($sformatf("%s_pkt%0d", tag, i), pk[base + i], exp_pkt[i]);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pkt", i2c_packet, 0);
        chk("rst_wr", wr_i2c, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_eidx", err_index, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // full sequence, default and overridden formats
        start_seq("t1");
        wait_done("t1");
        check_seq("t1");
        chk("t6_nwr", npk2 - base2, 11);
        chk("t6_pkt8", pk2[base2 + 8], 24'h340E4A);
        chk("t6_pkt9", pk2[base2 + 9], 24'h34100C);
        chk("t6_pkt10", pk2[base2 + 10], 24'h341201);

        // restart from DONE
        start_seq("t5a");
        wait_done("t5a");
        check_seq("t5a");

        // master never leaves idle: WAIT_ACCEPT timeout
        hold_high = 1'b1;
        start_seq("t2");
        wait_err("t2");
        chk("t2_eidx", err_index, 0);
        repeat (50) @(negedge clk);
        chk("t2_nwr", npk - base, 1);
        hold_high = 1'b0;
        repeat (3) @(negedge clk);

        // master stalls during write 5: WAIT_DONE timeout
        stall_en  = 1'b1;
        stall_idx = 5;
        start_seq("t3");
        wait_err("t3");
        chk("t3_eidx", err_index, 5);
        chk("t3_wd_cycles", 32'(int'(($time - drop_t) / 10) - 1), TIMEOUT);
        chk("t3_nwr", npk - base, 6);
        stall_en = 1'b0;
        repeat (5) @(negedge clk);

        // restart from ERROR
        start_seq("t5b");
        wait_done("t5b");
        check_seq("t5b");

        // start ignored while busy, then reset at write 3
        start_seq("t4");
        for (int i = 0; i < 1000 && (npk - base) < 2; i++) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 1000 && (npk - base) < 4; i++) @(negedge clk);
        chk("t4_reached_w3", npk - base, 4);
        chk("t4_pkt2", pk[base + 2], exp_pkt[2]);
        chk("t4_pkt3", pk[base + 3], exp_pkt[3]);
        reset = 1'b1;
        @(negedge clk);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_wr", wr_i2c, 0);
        chk("t4_rst_pkt", i2c_packet, 0);
        chk("t4_rst_done", done, 0);
        chk("t4_rst_err", err, 0);
        chk("t4_rst_eidx", err_index, 0);
        reset = 1'b0;
        repeat (250) @(negedge clk);
        chk("t4_no_more_wr", npk - base, 4);
        chk("t4_idle_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
